// File: rtl/capture_pkg.sv
// Shared definitions for the result capture buffer.
//   - FSM state encoding (IDLE/CAPTURE/DONE)
//   - default data/address widths
//   - burst length clamp helper
package capture_pkg;

  localparam int unsigned CAP_DATA_W = 32;
  localparam int unsigned CAP_ADDR_W = 10;

  // Largest burst the default RAM holds; a requested length of 0 also maps here.
  localparam int unsigned CAP_MAX_LEN = 1 << CAP_ADDR_W;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CAPTURE = 2'd1;
  localparam logic [1:0] ST_DONE    = 2'd2;

  // Clamp a requested burst length to the RAM depth; 0 means "fill the RAM".
  function automatic logic [31:0] clamp_len(input logic [31:0] len,
                                            input int unsigned addr_w);
    logic [31:0] depth;
    depth = 32'd1 << addr_w;
    return (len == 32'd0 || len > depth) ? depth : len;
  endfunction

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// Read-during-write to the same address returns the old word.
// No reset on the array or read register so it maps onto block RAM.
//   clk          : clock
//   we/waddr/wdata : write port
//   re/raddr     : read request, data appears on rdata one edge later
//   rdata        : registered read data, holds between reads
module capture_ram #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/result_capture_buffer.sv
// Avalon-ST sink capturing a fixed-length burst of results into RAM, with an
// Avalon-MM read slave (fixed 1-cycle latency) for the control processor.
//   clk, reset        : clock, async active-high reset
//   enable            : global enable for sample acceptance
//   data_in(_valid)   : stream samples
//   capture_start/len : arm a new burst (ignored while capturing)
//   avs_*             : read slave, readdatavalid one cycle after read
//   busy, done, count : burst status
module result_capture_buffer
  import capture_pkg::*;
#(
  parameter int DATA_W = CAP_DATA_W,
  parameter int ADDR_W = CAP_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_in_valid,
  input  logic              capture_start,
  input  logic [31:0]       capture_len,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  output logic [DATA_W-1:0] avs_readdata,
  output logic              avs_readdatavalid,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   count
);

  logic [1:0]        state;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   count_nxt;
  logic              wr_en;
  logic              rd_vld;
  logic              rd_primed;
  logic [DATA_W-1:0] ram_q;

  assign wr_en     = (state == ST_CAPTURE) && enable && data_in_valid;
  assign count_nxt = count + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      count <= '0;
      len_q <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (capture_start) begin
            state <= ST_CAPTURE;
            count <= '0;
            len_q <= (ADDR_W+1)'(clamp_len(capture_len, ADDR_W));
          end
        end
        ST_CAPTURE: begin
          // count < len_q <= depth here, so the write address never wraps
          if (wr_en) begin
            count <= count_nxt;
            if (count_nxt == len_q) state <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state == ST_CAPTURE);
  assign done = (state == ST_DONE);

  capture_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (count[ADDR_W-1:0]),
    .wdata (data_in),
    .re    (avs_read),
    .raddr (avs_address),
    .rdata (ram_q)
  );

  // The RAM read register has no reset; rd_primed forces readdata to 0 from
  // reset until the first read so the bus sees a defined value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_vld    <= 1'b0;
      rd_primed <= 1'b0;
    end else begin
      rd_vld <= avs_read;
      if (avs_read) rd_primed <= 1'b1;
    end
  end

  assign avs_readdatavalid = rd_vld;
  assign avs_readdata      = rd_primed ? ram_q : '0;

endmodule
